mc_ctrl: RTL and testbench

Multicycle control sequencer for the MIPS datapath. It decodes the instruction register's opcode/funct fields, steps through fetch/decode/execute/memory/writeback states, and drives the ALU's `aluop` plus all datapath enables and mux selects. It consumes the ALU `zero` flag for branch resolution and a memory `mem_ready` handshake. It sits between the instruction register and the datapath, producing the `aluop` that the ALU consumes.

---
 rtl/mc_ctrl_if.sv | 35 +++
 rtl/mc_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Control bus between the mc_ctrl sequencer and the MIPS multicycle datapath.
// The sequencer uses the master modport; the datapath side uses slave.
interface mc_ctrl_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic [3:0] aluop;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       pc_en;
   logic [1:0] pc_source;
   logic       illegal;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output aluop, alu_src_a, alu_src_b, iord, mem_read, mem_write,
             ir_write, reg_write, reg_dst, mem_to_reg, pc_en, pc_source,
             illegal
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  aluop, alu_src_a, alu_src_b, iord, mem_read, mem_write,
             ir_write, reg_write, reg_dst, mem_to_reg, pc_en, pc_source,
             illegal
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control sequencer: fetch/decode/execute/memory/writeback FSM.
// Define MC_CTRL_JUMP_EN to build the JUMP state; otherwise opcode j is illegal.
module mc_ctrl (
   input logic       clk,
   input logic       rst_n,
   mc_ctrl_if.master bus
);

   localparam logic [3:0] ALU_ADD = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0000;
   localparam logic [3:0] ALU_CLR = 4'b1001;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
`ifdef MC_CTRL_JUMP_EN
   localparam logic [5:0] OP_J     = 6'b000010;
`endif

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_R_EXEC   = 4'd2,
      S_R_WB     = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WB   = 4'd6,
      S_MEM_WR   = 4'd7,
      S_BRANCH   = 4'd8,
      S_I_EXEC   = 4'd9,
      S_I_WB     = 4'd10
`ifdef MC_CTRL_JUMP_EN
      , S_JUMP   = 4'd11
`endif
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] opc_q, opc_d;
   logic [5:0] fun_q, fun_d;

   logic [3:0] aluop;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       pc_en;
   logic [1:0] pc_source;
   logic       illegal;

   function automatic logic funct_ok(input logic [5:0] f);
      return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
             (f == FN_OR)  || (f == FN_XOR) || (f == FN_SLT);
   endfunction

   function automatic logic [3:0] r_aluop(input logic [5:0] f);
      logic [3:0] op;
      op = ALU_CLR;
      case (f)
         FN_ADD:  op = ALU_ADD;
         FN_SUB:  op = ALU_SUB;
         FN_AND:  op = ALU_AND;
         FN_OR:   op = ALU_OR;
         FN_XOR:  op = ALU_XOR;
         FN_SLT:  op = ALU_SLT;
         default: op = ALU_CLR;
      endcase
      return op;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         opc_q   <= '0;
         fun_q   <= '0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         fun_q   <= fun_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      opc_d      = opc_q;
      fun_d      = fun_q;
      aluop      = ALU_CLR;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      pc_en      = 1'b0;
      pc_source  = 2'd0;
      illegal    = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'd1;
            aluop     = ALU_ADD;
            ir_write  = bus.mem_ready;
            pc_en     = bus.mem_ready;
            if (bus.mem_ready) state_d = S_DECODE;
         end

         // The live IR is only trusted here; later states use the captured copy.
         S_DECODE: begin
            alu_src_b = 2'd2;
            aluop     = ALU_ADD;
            opc_d     = bus.opcode;
            fun_d     = bus.funct;
            state_d   = S_FETCH;
            case (bus.opcode)
               OP_RTYPE: begin
                  if (funct_ok(bus.funct)) state_d = S_R_EXEC;
                  else                     illegal = 1'b1;
               end
               OP_LW, OP_SW:    state_d = S_MEM_ADDR;
               OP_BEQ:          state_d = S_BRANCH;
               OP_ADDI, OP_ORI: state_d = S_I_EXEC;
`ifdef MC_CTRL_JUMP_EN
               OP_J:            state_d = S_JUMP;
`endif
               default:         illegal = 1'b1;
            endcase
         end

         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd0;
            aluop     = r_aluop(fun_q);
            state_d   = S_R_WB;
         end

         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_FETCH;
         end

         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            aluop     = ALU_ADD;
            state_d   = (opc_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end

         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (bus.mem_ready) state_d = S_MEM_WB;
         end

         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = S_FETCH;
         end

         S_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (bus.mem_ready) state_d = S_FETCH;
         end

         S_BRANCH: begin
            alu_src_a = 1'b1;
            aluop     = ALU_SUB;
            pc_source = 2'd1;
            pc_en     = bus.zero;
            state_d   = S_FETCH;
         end

         S_I_EXEC: begin
            alu_src_a = 1'b1;
            if (opc_q == OP_ORI) begin
               alu_src_b = 2'd3;
               aluop     = ALU_OR;
            end else begin
               alu_src_b = 2'd2;
               aluop     = ALU_ADD;
            end
            state_d = S_I_WB;
         end

         S_I_WB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end

`ifdef MC_CTRL_JUMP_EN
         S_JUMP: begin
            pc_source = 2'd2;
            pc_en     = 1'b1;
            state_d   = S_FETCH;
         end
`endif

         default: state_d = S_FETCH;
      endcase

      // Reset must silence every strobe immediately, not just after the edge.
      if (!rst_n) begin
         aluop      = ALU_ADD;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'd1;
         iord       = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         pc_en      = 1'b0;
         pc_source  = 2'd0;
         illegal    = 1'b0;
      end
   end

   assign bus.aluop      = aluop;
   assign bus.alu_src_a  = alu_src_a;
   assign bus.alu_src_b  = alu_src_b;
   assign bus.iord       = iord;
   assign bus.mem_read   = mem_read;
   assign bus.mem_write  = mem_write;
   assign bus.ir_write   = ir_write;
   assign bus.reg_write  = reg_write;
   assign bus.reg_dst    = reg_dst;
   assign bus.mem_to_reg = mem_to_reg;
   assign bus.pc_en      = pc_en;
   assign bus.pc_source  = pc_source;
   assign bus.illegal    = illegal;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle expected control vectors go through a scoreboard queue.
// Build with and without MC_CTRL_JUMP_EN; the j scenario follows the macro.
module tb_mc_ctrl;

   localparam logic [3:0] ADD = 4'b0101;
   localparam logic [3:0] SUB = 4'b0110;
   localparam logic [3:0] AND = 4'b0001;
   localparam logic [3:0] OR  = 4'b0010;
   localparam logic [3:0] XOR = 4'b0100;
   localparam logic [3:0] SLT = 4'b0000;
   localparam logic [3:0] CLR = 4'b1001;

   localparam logic [5:0] RT   = 6'b000000;
   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] ORI  = 6'b001101;
   localparam logic [5:0] JMP  = 6'b000010;
   localparam logic [5:0] BAD  = 6'b111111;

   typedef struct packed {
      logic        rst;
      logic [5:0]  opc;
      logic [5:0]  fn;
      logic        z;
      logic        mr;
      logic [17:0] want;
   } step_t;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   step_t       plan[$];
   logic [17:0] sb_q[$];
   logic [17:0] obs, want;

   always #5 clk = ~clk;

   mc_ctrl_if bus ();

   mc_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Packed order: aluop, src_a, src_b, iord, mem_read, mem_write, ir_write,
   // reg_write, reg_dst, mem_to_reg, pc_en, pc_source, illegal
   function automatic logic [17:0] pk(input logic [3:0] op, input logic sa, input logic [1:0] sb,
                                      input logic io, input logic mr, input logic mw, input logic irw,
                                      input logic rw, input logic rd, input logic mtr, input logic pce,
                                      input logic [1:0] pcs, input logic ill);
      return {op, sa, sb, io, mr, mw, irw, rw, rd, mtr, pce, pcs, ill};
   endfunction

   function automatic logic [17:0] observe();
      return {bus.aluop, bus.alu_src_a, bus.alu_src_b, bus.iord, bus.mem_read, bus.mem_write,
              bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.pc_en,
              bus.pc_source, bus.illegal};
   endfunction

   function automatic logic [17:0] e_reset();        return pk(ADD,0,2'd1,0,0,0,0,0,0,0,0,2'd0,0); endfunction
   function automatic logic [17:0] e_fetch(input logic r); return pk(ADD,0,2'd1,0,1,0,r,0,0,0,r,2'd0,0); endfunction
   function automatic logic [17:0] e_decode(input logic i); return pk(ADD,0,2'd2,0,0,0,0,0,0,0,0,2'd0,i); endfunction
   function automatic logic [17:0] e_rexec(input logic [3:0] op); return pk(op,1,2'd0,0,0,0,0,0,0,0,0,2'd0,0); endfunction
   function automatic logic [17:0] e_rwb();          return pk(CLR,0,2'd0,0,0,0,0,1,1,0,0,2'd0,0); endfunction
   function automatic logic [17:0] e_maddr();        return pk(ADD,1,2'd2,0,0,0,0,0,0,0,0,2'd0,0); endfunction
   function automatic logic [17:0] e_memrd();        return pk(CLR,0,2'd0,1,1,0,0,0,0,0,0,2'd0,0); endfunction
   function automatic logic [17:0] e_memwb();        return pk(CLR,0,2'd0,0,0,0,0,1,0,1,0,2'd0,0); endfunction
   function automatic logic [17:0] e_memwr();        return pk(CLR,0,2'd0,1,0,1,0,0,0,0,0,2'd0,0); endfunction
   function automatic logic [17:0] e_branch(input logic z); return pk(SUB,1,2'd0,0,0,0,0,0,0,0,z,2'd1,0); endfunction
   function automatic logic [17:0] e_iexec(input logic ori);
      return ori ? pk(OR,1,2'd3,0,0,0,0,0,0,0,0,2'd0,0) : pk(ADD,1,2'd2,0,0,0,0,0,0,0,0,2'd0,0);
   endfunction
   function automatic logic [17:0] e_iwb();          return pk(CLR,0,2'd0,0,0,0,0,1,0,0,0,2'd0,0); endfunction
   function automatic logic [17:0] e_jump();         return pk(CLR,0,2'd0,0,0,0,0,0,0,0,1,2'd2,0); endfunction

   task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic m, input logic [17:0] e);
      step_t s;
      s.rst = r; s.opc = o; s.fn = f; s.z = z; s.mr = m; s.want = e;
      plan.push_back(s);
   endtask

   task automatic apply(input step_t s);
      rst_n         = s.rst;
      bus.opcode    = s.opc;
      bus.funct     = s.fn;
      bus.zero      = s.z;
      bus.mem_ready = s.mr;
      sb_q.push_back(s.want);
   endtask

   task automatic test_reset();
      plan.delete();
      repeat (3) add(0, LW, 6'b100000, 1, 1, e_reset());
      add(1, LW, 6'b100000, 0, 1, e_fetch(1));
      add(1, BAD, 6'b000000, 0, 1, e_decode(1));
      for (int i = 0; i < plan.size(); i++) begin
         apply(plan[i]);
         @(negedge clk);
         obs = observe(); want = sb_q.pop_front(); checks++;
         if (obs !== want) begin
            errors++;
            $display("[TB] FAIL test_reset step %0d: got %b expected %b", i, obs, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_rtype();
      logic [5:0] fns [6];
      logic [3:0] ops [6];
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010};
      ops = '{ADD, SUB, AND, OR, XOR, SLT};
      plan.delete();
      for (int k = 0; k < 6; k++) begin
         add(1, SW, 6'b000000, 0, 1, e_fetch(1));
         add(1, RT, fns[k], 0, 1, e_decode(0));
         add(1, BAD, 6'b000000, 1, 0, e_rexec(ops[k]));
         add(1, LW, 6'b111111, 0, 0, e_rwb());
      end
      for (int i = 0; i < plan.size(); i++) begin
         apply(plan[i]);
         @(negedge clk);
         obs = observe(); want = sb_q.pop_front(); checks++;
         if (obs !== want) begin
            errors++;
            $display("[TB] FAIL test_rtype step %0d: got %b expected %b", i, obs, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem();
      plan.delete();
      add(1, RT, 6'b000000, 0, 1, e_fetch(1));
      add(1, LW, 6'b000000, 0, 1, e_decode(0));
      add(1, SW, 6'b000000, 0, 0, e_maddr());
      add(1, SW, 6'b000000, 0, 0, e_memrd());
      add(1, SW, 6'b000000, 0, 0, e_memrd());
      add(1, SW, 6'b000000, 0, 1, e_memrd());
      add(1, SW, 6'b000000, 0, 1, e_memwb());
      add(1, RT, 6'b000000, 0, 0, e_fetch(0));
      add(1, RT, 6'b000000, 0, 1, e_fetch(1));
      add(1, SW, 6'b000000, 0, 1, e_decode(0));
      add(1, LW, 6'b000000, 0, 1, e_maddr());
      add(1, LW, 6'b000000, 0, 0, e_memwr());
      add(1, LW, 6'b000000, 0, 1, e_memwr());
      for (int i = 0; i < plan.size(); i++) begin
         apply(plan[i]);
         @(negedge clk);
         obs = observe(); want = sb_q.pop_front(); checks++;
         if (obs !== want) begin
            errors++;
            $display("[TB] FAIL test_mem step %0d: got %b expected %b", i, obs, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch_imm();
      plan.delete();
      add(1, RT, 6'b000000, 1, 1, e_fetch(1));
      add(1, BEQ, 6'b000000, 1, 1, e_decode(0));
      add(1, BAD, 6'b000000, 1, 0, e_branch(1));
      add(1, RT, 6'b000000, 1, 1, e_fetch(1));
      add(1, BEQ, 6'b000000, 0, 0, e_decode(0));
      add(1, BEQ, 6'b000000, 0, 1, e_branch(0));
      add(1, RT, 6'b000000, 0, 1, e_fetch(1));
      add(1, ADDI, 6'b000000, 0, 1, e_decode(0));
      add(1, ORI, 6'b000000, 0, 1, e_iexec(0));
      add(1, ORI, 6'b000000, 0, 1, e_iwb());
      add(1, RT, 6'b000000, 0, 1, e_fetch(1));
      add(1, ORI, 6'b000000, 0, 1, e_decode(0));
      add(1, ADDI, 6'b000000, 0, 1, e_iexec(1));
      add(1, ADDI, 6'b000000, 0, 1, e_iwb());
      for (int i = 0; i < plan.size(); i++) begin
         apply(plan[i]);
         @(negedge clk);
         obs = observe(); want = sb_q.pop_front(); checks++;
         if (obs !== want) begin
            errors++;
            $display("[TB] FAIL test_branch_imm step %0d: got %b expected %b", i, obs, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal_jump();
      plan.delete();
      add(1, RT, 6'b000000, 0, 1, e_fetch(1));
      add(1, BAD, 6'b100000, 0, 1, e_decode(1));
      add(1, RT, 6'b000000, 0, 1, e_fetch(1));
      add(1, RT, 6'b000000, 0, 1, e_decode(1));
      add(1, RT, 6'b000000, 0, 1, e_fetch(1));
`ifdef MC_CTRL_JUMP_EN
      add(1, JMP, 6'b000000, 0, 1, e_decode(0));
      add(1, BAD, 6'b000000, 0, 1, e_jump());
`else
      add(1, JMP, 6'b000000, 0, 1, e_decode(1));
`endif
      for (int i = 0; i < plan.size(); i++) begin
         apply(plan[i]);
         @(negedge clk);
         obs = observe(); want = sb_q.pop_front(); checks++;
         if (obs !== want) begin
            errors++;
            $display("[TB] FAIL test_illegal_jump step %0d: got %b expected %b", i, obs, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_write();
      plan.delete();
      add(1, RT, 6'b000000, 0, 1, e_fetch(1));
      add(1, SW, 6'b000000, 0, 1, e_decode(0));
      add(1, SW, 6'b000000, 0, 1, e_maddr());
      add(1, SW, 6'b000000, 0, 0, e_memwr());
      add(0, SW, 6'b000000, 0, 0, e_reset());
      add(1, SW, 6'b000000, 0, 0, e_fetch(0));
      add(1, RT, 6'b000000, 0, 1, e_fetch(1));
      add(1, LW, 6'b000000, 0, 1, e_decode(0));
      add(0, LW, 6'b000000, 0, 1, e_reset());
      add(1, LW, 6'b000000, 0, 0, e_fetch(0));
      for (int i = 0; i < plan.size(); i++) begin
         apply(plan[i]);
         @(negedge clk);
         obs = observe(); want = sb_q.pop_front(); checks++;
         if (obs !== want) begin
            errors++;
            $display("[TB] FAIL test_reset_mid_write step %0d: got %b expected %b", i, obs, want);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.opcode    = '0;
      bus.funct     = '0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;
      #1;
      $display("[TB] starting mc_ctrl scenarios");
      test_reset();
      test_rtype();
      test_mem();
      test_branch_imm();
      test_illegal_jump();
      test_reset_mid_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
